// File: rtl/sec32_pkg.sv
// rtl/sec32_pkg.sv - SEC32 constants, parity masks, codeword type and check-bit function
package sec32_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CW_W   = 40;

    // Parity-group masks over the data word; every group holds 12 bits.
    localparam logic [DATA_W-1:0] SEC32_MASK_C0 = 32'h00FF_1111;
    localparam logic [DATA_W-1:0] SEC32_MASK_C1 = 32'hFF00_2222;
    localparam logic [DATA_W-1:0] SEC32_MASK_C2 = 32'h0F0F_4444;
    localparam logic [DATA_W-1:0] SEC32_MASK_C3 = 32'hF0F0_8888;
    localparam logic [DATA_W-1:0] SEC32_MASK_C4 = 32'h1111_00FF;
    localparam logic [DATA_W-1:0] SEC32_MASK_C5 = 32'h2222_FF00;
    localparam logic [DATA_W-1:0] SEC32_MASK_C6 = 32'h4444_0F0F;
    localparam logic [DATA_W-1:0] SEC32_MASK_C7 = 32'h8888_F0F0;

    localparam logic [CHK_W-1:0][DATA_W-1:0] SEC32_MASKS = {
        SEC32_MASK_C7, SEC32_MASK_C6, SEC32_MASK_C5, SEC32_MASK_C4,
        SEC32_MASK_C3, SEC32_MASK_C2, SEC32_MASK_C1, SEC32_MASK_C0
    };

    // Check sits in the upper bits so codeword bit index i matches the
    // injection index: 0..31 data, 32..39 check bit (i-32).
    typedef struct packed {
        logic [CHK_W-1:0]  check;
        logic [DATA_W-1:0] data;
    } codeword_t;

    typedef enum logic {
        INJ_IDLE  = 1'b0,
        INJ_ARMED = 1'b1
    } inj_state_e;

    function automatic logic [CHK_W-1:0] sec32_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] c;
        for (int k = 0; k < CHK_W; k++) begin
            c[k] = ^(data & SEC32_MASKS[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sec32_encoder_stream_if.sv
// rtl/sec32_encoder_stream_if.sv - input, output and injection handshakes of the SEC32 encoder
interface sec32_encoder_stream_if;
    import sec32_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHK_W-1:0]  out_check;
    logic              inj_valid;
    logic              inj_ready;
    logic [5:0]        inj_idx;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready, inj_valid, inj_idx,
        input  in_ready, out_valid, out_data, out_check, inj_ready
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_data, out_ready, inj_valid, inj_idx,
        output in_ready, out_valid, out_data, out_check, inj_ready
    );

endinterface

// File: rtl/sec32_skid_buf.sv
// rtl/sec32_skid_buf.sv - 2-entry valid/ready buffer (output register + skid register) of codewords
module sec32_skid_buf
    import sec32_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  codeword_t in_data_i,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output codeword_t out_data_o
);

    codeword_t out_q,  out_d;
    codeword_t skid_q, skid_d;
    logic      out_v_q,  out_v_d;
    logic      skid_v_q, skid_v_d;
    logic      push;
    logic      pop;

    // Ready depends only on the skid flop, so there is no path from out_ready.
    assign in_ready_o  = ~skid_v_q;
    assign out_valid_o = out_v_q;
    assign out_data_o  = out_q;

    // Refill the output from skid first, else from the input; park input in skid when stalled.
    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        push     = in_valid_i && !skid_v_q;
        pop      = out_v_q && out_ready_i;
        if (!out_v_q || pop) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else if (push) begin
                out_d   = in_data_i;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (push) begin
            skid_d   = in_data_i;
            skid_v_d = 1'b1;
        end
    end

    // Buffer state registers; reset drops both entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

endmodule

// File: rtl/sec32_encoder_stream.sv
// rtl/sec32_encoder_stream.sv - streaming SEC32 encoder with one-shot error injection (option: LOCK_KEY_EN)
module sec32_encoder_stream
    import sec32_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int KEY_W = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    sec32_encoder_stream_if.slave bus,
    output logic [CNT_W-1:0]     words_cnt,
    output logic [CNT_W-1:0]     inj_cnt
`ifdef LOCK_KEY_EN
    ,
    input  logic [KEY_W-1:0]     key
`endif
);

    inj_state_e       state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [5:0]       eff_idx;
    logic             arm;
    logic             accept;
    logic             apply_flip;
    logic             in_ready;
    logic [KEY_W-1:0] key_w;
    logic [CW_W-1:0]  flip_mask;
    codeword_t        enc_cw;
    codeword_t        buf_in;
    codeword_t        buf_out;
    logic [CNT_W-1:0] words_cnt_q;
    logic [CNT_W-1:0] inj_cnt_q;

`ifdef LOCK_KEY_EN
    assign key_w = key;
`else
    assign key_w = '0;
`endif

    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.inj_ready = (state_q == INJ_IDLE);
    assign bus.out_data  = buf_out.data;
    assign bus.out_check = buf_out.check;
    assign words_cnt     = words_cnt_q;
    assign inj_cnt       = inj_cnt_q;

    // Encode the incoming word; the key mix is applied before any injected flip.
    always_comb begin
        enc_cw.data  = bus.in_data;
        enc_cw.check = sec32_check(bus.in_data) ^ key_w[CHK_W-1:0];
        flip_mask    = apply_flip ? (CW_W'(1) << eff_idx) : '0;
        buf_in       = enc_cw ^ flip_mask;
    end

    // Injection FSM: an arm in the same cycle as an accept hits that word.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        apply_flip = 1'b0;
        arm        = bus.inj_valid && (state_q == INJ_IDLE);
        eff_idx    = (state_q == INJ_ARMED) ? idx_q : bus.inj_idx;
        if ((state_q == INJ_ARMED) || arm) begin
            if (accept) begin
                state_d    = INJ_IDLE;
                apply_flip = (eff_idx < 6'(CW_W));
            end else begin
                state_d = INJ_ARMED;
                idx_d   = eff_idx;
            end
        end
    end

    // Injection state and latched index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INJ_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Wrapping counters for emitted codewords and applied flips.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_cnt_q <= '0;
            inj_cnt_q   <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                words_cnt_q <= words_cnt_q + 1'b1;
            end
            if (apply_flip) begin
                inj_cnt_q <= inj_cnt_q + 1'b1;
            end
        end
    end

    sec32_skid_buf u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (buf_in),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (buf_out)
    );

endmodule

// File: tb/tb_sec32_encoder_stream.sv
// tb/tb_sec32_encoder_stream.sv - directed self-checking bench for sec32_encoder_stream
module tb_sec32_encoder_stream;

`ifdef LOCK_KEY_EN
    localparam logic [7:0] KX = 8'hA5;
`else
    localparam logic [7:0] KX = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] words_cnt;
    logic [15:0] inj_cnt;
    int          checks = 0;
    int          errors = 0;

    sec32_encoder_stream_if bus ();

    sec32_encoder_stream #(.CNT_W(16), .KEY_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .words_cnt (words_cnt),
        .inj_cnt   (inj_cnt)
`ifdef LOCK_KEY_EN
        ,
        .key       (KX)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.inj_valid = 1'b0;
        bus.inj_idx   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 40'(bus.out_valid), 40'd0);
        chk("rst_out_data",  40'(bus.out_data), 40'd0);
        chk("rst_out_check", 40'(bus.out_check), 40'd0);
        chk("rst_in_ready",  40'(bus.in_ready), 40'd1);
        chk("rst_inj_ready", 40'(bus.inj_ready), 40'd1);
        chk("rst_words_cnt", 40'(words_cnt), 40'd0);
        chk("rst_inj_cnt",   40'(inj_cnt), 40'd0);
        rst_n = 1'b1;
        tick();

        // Single words, streamed back to back
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0000;
        tick();
        chk("w0_valid", 40'(bus.out_valid), 40'd1);
        chk("w0_check", 40'(bus.out_check), 40'(8'h00 ^ KX));
        bus.in_data = 32'h0000_0001;
        tick();
        chk("w1_data",  40'(bus.out_data), 40'h0000_0001);
        chk("w1_check", 40'(bus.out_check), 40'(8'h51 ^ KX));
        bus.in_data = 32'h8000_0000;
        tick();
        chk("w2_check", 40'(bus.out_check), 40'(8'h8A ^ KX));
        chk("w2_cnt",   40'(words_cnt), 40'd2);
        bus.in_data = 32'hFFFF_FFFF;
        tick();
        chk("w3_check", 40'(bus.out_check), 40'(8'h00 ^ KX));
        bus.in_valid = 1'b0;
        tick();
        chk("w_drain_valid", 40'(bus.out_valid), 40'd0);
        chk("w_drain_cnt",   40'(words_cnt), 40'd4);

        // Backpressure: 4 words, out_ready low for 3 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1111_1111;
        tick();
        chk("bp_a0_data", 40'(bus.out_data), 40'h1111_1111);
        chk("bp_rdy1",    40'(bus.in_ready), 40'd1);
        bus.in_data = 32'h2222_2222;
        tick();
        chk("bp_rdy_drop", 40'(bus.in_ready), 40'd0);
        chk("bp_stable1",  40'(bus.out_data), 40'h1111_1111);
        bus.in_data = 32'h3333_3333;
        tick();
        chk("bp_stable2", 40'(bus.out_data), 40'h1111_1111);
        chk("bp_stable2_chk", 40'(bus.out_check), 40'(8'h00 ^ KX));
        chk("bp_rdy_held", 40'(bus.in_ready), 40'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_a1_data", 40'(bus.out_data), 40'h2222_2222);
        chk("bp_rdy_back", 40'(bus.in_ready), 40'd1);
        tick();
        chk("bp_a2_data", 40'(bus.out_data), 40'h3333_3333);
        bus.in_data = 32'h4444_4444;
        tick();
        chk("bp_a3_data", 40'(bus.out_data), 40'h4444_4444);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 40'(bus.out_valid), 40'd0);
        chk("bp_words_cnt",   40'(words_cnt), 40'd8);

        // Injection armed in the same cycle as the word
        bus.inj_valid = 1'b1;
        bus.inj_idx   = 6'd5;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0000;
        tick();
        bus.inj_valid = 1'b0;
        bus.in_valid  = 1'b0;
        chk("inj5_data",  40'(bus.out_data), 40'h0000_0020);
        chk("inj5_check", 40'(bus.out_check), 40'(8'h00 ^ KX));
        chk("inj5_cnt",   40'(inj_cnt), 40'd1);
        chk("inj5_ready", 40'(bus.inj_ready), 40'd1);
        tick();

        // Out-of-range index consumes the slot without a flip
        bus.inj_valid = 1'b1;
        bus.inj_idx   = 6'd45;
        tick();
        bus.inj_valid = 1'b0;
        chk("inj45_armed", 40'(bus.inj_ready), 40'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        tick();
        bus.in_valid = 1'b0;
        chk("inj45_data",  40'(bus.out_data), 40'h0000_0001);
        chk("inj45_check", 40'(bus.out_check), 40'(8'h51 ^ KX));
        chk("inj45_cnt",   40'(inj_cnt), 40'd1);
        chk("inj45_ready", 40'(bus.inj_ready), 40'd1);
        tick();

        // Check-bit index 39 flips c7
        bus.inj_valid = 1'b1;
        bus.inj_idx   = 6'd39;
        tick();
        bus.inj_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0001;
        tick();
        bus.in_valid = 1'b0;
        chk("inj39_data",  40'(bus.out_data), 40'h0000_0001);
        chk("inj39_check", 40'(bus.out_check), 40'(8'hD1 ^ KX));
        chk("inj39_cnt",   40'(inj_cnt), 40'd2);
        tick();

        // Reset mid-stream with 2 words buffered and an injection armed
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hAAAA_0001;
        tick();
        bus.in_data = 32'hAAAA_0002;
        tick();
        bus.in_valid  = 1'b0;
        bus.inj_valid = 1'b1;
        bus.inj_idx   = 6'd3;
        tick();
        bus.inj_valid = 1'b0;
        chk("pre_rst_full",  40'(bus.in_ready), 40'd0);
        chk("pre_rst_armed", 40'(bus.inj_ready), 40'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid",  40'(bus.out_valid), 40'd0);
        chk("mid_rst_words",  40'(words_cnt), 40'd0);
        chk("mid_rst_inj",    40'(inj_cnt), 40'd0);
        chk("mid_rst_injrdy", 40'(bus.inj_ready), 40'd1);
        chk("mid_rst_inrdy",  40'(bus.in_ready), 40'd1);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0000;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_noflip", 40'(bus.out_data), 40'h0000_0000);
        chk("post_rst_inj",    40'(inj_cnt), 40'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
